// File: rtl/ntt_defines_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ntt_defines_pkg
// Description : Shared types and constants for the masked NTT datapath.
//               masked_coeff_t holds one coefficient as two Boolean shares,
//               index [0] = share0 and index [1] = share1.
// Revision    : 1.0 - initial release
// ============================================================================
package ntt_defines_pkg;

  localparam int MASKED_COEFF_WIDTH  = 23;
  localparam int MASKED_ADDER_LAT    = 27;
  localparam int MASKED_OUTBUF_DEPTH = 4;

  typedef logic [1:0][MASKED_COEFF_WIDTH-1:0] masked_coeff_t;

  // Width of a counter that must hold every value from 0 to depth inclusive.
  function automatic int masked_cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ntt_masked_outbuf_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ntt_masked_outbuf_fifo
// Description : Small FIFO holding Boolean-masked result share pairs.
//               Shares are stored and presented side by side and are never
//               combined with each other. zeroize wipes storage, pointers
//               and count synchronously.
// Ports       : clk, rst_n (async, active-low), zeroize
//               push / push_data  - write one share pair at the tail
//               pop               - consume the head (ignored when empty)
//               count             - number of occupied entries
//               head              - head share pair, zero when empty
// Revision    : 1.0 - initial release
// ============================================================================
module ntt_masked_outbuf_fifo
  import ntt_defines_pkg::*;
#(
  parameter int WIDTH = MASKED_COEFF_WIDTH,
  parameter int DEPTH = MASKED_OUTBUF_DEPTH,
  parameter int CNT_W = masked_cnt_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  zeroize,
  input  logic                  push,
  input  logic [1:0][WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [CNT_W-1:0]      count,
  output logic [1:0][WIDTH-1:0] head
);

  localparam int                 c_ptr_w    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_ptr_w-1:0] c_ptr_last = c_ptr_w'(DEPTH - 1);
  localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);
  localparam logic [CNT_W-1:0]   c_cnt_one  = CNT_W'(1);
  localparam logic [CNT_W-1:0]   c_full     = CNT_W'(DEPTH);

  logic [1:0][WIDTH-1:0] r_mem [DEPTH];
  logic [c_ptr_w-1:0]    r_wr_ptr;
  logic [c_ptr_w-1:0]    r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  w_pop;

  function automatic logic [c_ptr_w-1:0] f_ptr_next(input logic [c_ptr_w-1:0] ptr);
    return (ptr == c_ptr_last) ? '0 : ptr + c_ptr_one;
  endfunction

  assign w_pop = pop & (r_count != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (zeroize) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= f_ptr_next(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= f_ptr_next(r_rd_ptr);
      end
      case ({push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

  // Gating the head keeps stale share pairs off the output once popped.
  assign head  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
  assign count = r_count;

  // Upstream credits must make an unmatched push into a full FIFO impossible.
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !w_pop && (r_count == c_full)));

endmodule
`default_nettype wire

// File: rtl/ntt_masked_adder_out_buffer.sv
`default_nettype none
// ============================================================================
// Module      : ntt_masked_adder_out_buffer
// Description : Credit-controlled issue and output buffer for the fixed-
//               latency masked special adder. Operands are admitted only
//               when in-flight plus buffered tokens leave room in the FIFO,
//               a LAT-deep valid pipe marks when results emerge, and the
//               share pairs are captured and offered with ready/valid.
// Ports       : clk, rst_n (async, active-low), zeroize (sync wipe)
//               in_valid_i / in_ready_o   - operand issue handshake
//               adder_res_i               - adder result share pair
//               out_valid_o / out_ready_i - result handshake
//               out_masked_o              - head share pair
//               rnd_refresh_i             - re-mask randomness (macro only)
//               busy_o                    - tokens in flight or buffered
// Options     : NTT_MASKED_OUTBUF_REFRESH_EN - when defined, both shares are
//               XORed with rnd_refresh_i on capture (unmasked value kept).
// Revision    : 1.0 - initial release
// ============================================================================
module ntt_masked_adder_out_buffer
  import ntt_defines_pkg::*;
#(
  parameter int WIDTH = MASKED_COEFF_WIDTH,
  parameter int LAT   = MASKED_ADDER_LAT,
  parameter int DEPTH = MASKED_OUTBUF_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  zeroize,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [1:0][WIDTH-1:0] adder_res_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [1:0][WIDTH-1:0] out_masked_o,
`ifdef NTT_MASKED_OUTBUF_REFRESH_EN
  input  logic [WIDTH-1:0]      rnd_refresh_i,
`endif
  output logic                  busy_o
);

  localparam int                 c_cnt_w   = masked_cnt_width(DEPTH);
  localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
  localparam logic [c_cnt_w:0]   c_credits = (c_cnt_w + 1)'(DEPTH);

  logic [LAT-1:0]        r_vpipe;
  logic [c_cnt_w-1:0]    r_inflight;
  logic [c_cnt_w-1:0]    w_fifo_cnt;
  logic [c_cnt_w:0]      w_credits_used;
  logic                  w_acc;
  logic                  w_emerge;
  logic                  w_push;
  logic                  w_pop;
  logic [1:0][WIDTH-1:0] w_push_data;

  // Credits come from registered counts only, so a pop frees its slot one
  // cycle later and never creates a combinational path to in_ready_o.
  assign w_credits_used = {1'b0, r_inflight} + {1'b0, w_fifo_cnt};
  assign in_ready_o     = !zeroize && (w_credits_used < c_credits);
  assign w_acc          = in_valid_i & in_ready_o;
  assign w_emerge       = r_vpipe[LAT-1];
  assign w_push         = w_emerge & ~zeroize;
  assign w_pop          = out_valid_o & out_ready_i;

  generate
    if (LAT > 1) begin : g_vpipe_multi
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       r_vpipe <= '0;
        else if (zeroize) r_vpipe <= '0;
        else              r_vpipe <= {r_vpipe[LAT-2:0], w_acc};
      end
    end else begin : g_vpipe_single
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       r_vpipe <= '0;
        else if (zeroize) r_vpipe <= '0;
        else              r_vpipe <= w_acc;
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= '0;
    end else if (zeroize) begin
      r_inflight <= '0;
    end else begin
      case ({w_acc, w_emerge})
        2'b10:   r_inflight <= r_inflight + c_cnt_one;
        2'b01:   r_inflight <= r_inflight - c_cnt_one;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

`ifdef NTT_MASKED_OUTBUF_REFRESH_EN
  // Same mask on both shares: each share is re-randomised while the
  // unmasked value share0^share1 is unchanged.
  assign w_push_data[0] = adder_res_i[0] ^ rnd_refresh_i;
  assign w_push_data[1] = adder_res_i[1] ^ rnd_refresh_i;
`else
  assign w_push_data = adder_res_i;
`endif

  ntt_masked_outbuf_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .CNT_W (c_cnt_w)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .zeroize   (zeroize),
    .push      (w_push),
    .push_data (w_push_data),
    .pop       (w_pop),
    .count     (w_fifo_cnt),
    .head      (out_masked_o)
  );

  assign out_valid_o = (w_fifo_cnt != '0);
  assign busy_o      = ((r_inflight | w_fifo_cnt) != '0);

endmodule
`default_nettype wire
